// File: rtl/rc4_keystream_engine.sv
// RC4 keystream engine: one sequencer drives the external 256x8 S-memory through
// S-box init, key scheduling and PRGA, then hands bytes out over valid/ready.
module rc4_keystream_engine #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic [7:0]             address,
  output logic [7:0]             data,
  output logic                   wren,
  output logic                   rden,
  input  logic [7:0]             q,
  output logic [7:0]             ks_byte,
  output logic                   ks_valid,
  input  logic                   ks_ready,
  output logic [7:0]             ks_index,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [4:0] {
    S_IDLE, S_INIT,
    S_K_RDI, S_K_WTI, S_K_RDJ, S_K_WTJ, S_K_WRI, S_K_WRJ,
    S_P_RDI, S_P_WTI, S_P_RDJ, S_P_WTJ, S_P_WRI, S_P_WRJ, S_P_RDT, S_P_WTT,
    S_OUT, S_DONE
  } state_t;

  state_t               r_state, w_next;
  logic [7:0]           r_i, r_j, r_k, r_ks, r_si, r_sj;
  logic [4:0]           r_ksel;
  logic [1:0]           r_wcnt;
  logic [8*KEY_BYTES-1:0] r_key;
  logic                 w_last_wait, w_accept, w_last_k;
  logic [7:0]           w_kbyte, w_i_inc;

  // r_ksel counts down so that key byte 0 (the MSB) is used first
  assign w_kbyte     = 8'(r_key >> {r_ksel, 3'b000});
  assign w_i_inc     = r_i + 8'd1;
  assign w_last_wait = (r_wcnt == 2'(RD_LAT - 1));
  assign w_accept    = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last_k    = (r_k == 8'(MSG_LEN - 1));

  assign ks_byte  = r_ks;
  assign ks_index = r_k;
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done     = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    address  = 8'd0;
    data     = 8'd0;
    wren     = 1'b0;
    rden     = 1'b0;
    ks_valid = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_INIT;
      S_INIT: begin
        address = r_i;
        data    = r_i;
        wren    = 1'b1;
        if (r_i == 8'hFF) w_next = S_K_RDI;
      end
      S_K_RDI: begin rden = 1'b1; address = r_i; w_next = S_K_WTI; end
      S_K_WTI: if (w_last_wait) w_next = S_K_RDJ;
      S_K_RDJ: begin rden = 1'b1; address = r_j; w_next = S_K_WTJ; end
      S_K_WTJ: if (w_last_wait) w_next = S_K_WRI;
      S_K_WRI: begin wren = 1'b1; address = r_i; data = r_sj; w_next = S_K_WRJ; end
      S_K_WRJ: begin
        wren    = 1'b1;
        address = r_j;
        data    = r_si;
        w_next  = (r_i == 8'hFF) ? S_P_RDI : S_K_RDI;
      end
      S_P_RDI: begin rden = 1'b1; address = w_i_inc; w_next = S_P_WTI; end
      S_P_WTI: if (w_last_wait) w_next = S_P_RDJ;
      S_P_RDJ: begin rden = 1'b1; address = r_j; w_next = S_P_WTJ; end
      S_P_WTJ: if (w_last_wait) w_next = S_P_WRI;
      S_P_WRI: begin wren = 1'b1; address = r_i; data = r_sj; w_next = S_P_WRJ; end
      S_P_WRJ: begin wren = 1'b1; address = r_j; data = r_si; w_next = S_P_RDT; end
      S_P_RDT: begin rden = 1'b1; address = r_si + r_sj; w_next = S_P_WTT; end
      S_P_WTT: if (w_last_wait) w_next = S_OUT;
      S_OUT: begin
        ks_valid = 1'b1;
        if (ks_ready) w_next = w_last_k ? S_DONE : S_P_RDI;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Control counters and the keystream output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_i    <= 8'd0;
      r_j    <= 8'd0;
      r_k    <= 8'd0;
      r_ks   <= 8'd0;
      r_wcnt <= 2'd0;
      r_ksel <= 5'(KEY_BYTES - 1);
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (w_accept) begin
          r_i    <= 8'd0;
          r_j    <= 8'd0;
          r_k    <= 8'd0;
          r_wcnt <= 2'd0;
          r_ksel <= 5'(KEY_BYTES - 1);
        end
        S_INIT: begin
          r_i <= w_i_inc;
          if (r_i == 8'hFF) r_j <= 8'd0;
        end
        S_K_WTI, S_K_WTJ, S_P_WTI, S_P_WTJ, S_P_WTT: begin
          r_wcnt <= w_last_wait ? 2'd0 : r_wcnt + 2'd1;
          if (w_last_wait && r_state == S_K_WTI) r_j <= r_j + q + w_kbyte;
          if (w_last_wait && r_state == S_P_WTI) r_j <= r_j + q;
          if (w_last_wait && r_state == S_P_WTT) r_ks <= q;
        end
        S_K_WRJ: begin
          r_i    <= w_i_inc;
          r_ksel <= (r_ksel == 5'd0) ? 5'(KEY_BYTES - 1) : r_ksel - 5'd1;
          if (r_i == 8'hFF) r_j <= 8'd0;
        end
        S_P_RDI: r_i <= w_i_inc;
        S_OUT:   if (ks_ready && !w_last_k) r_k <= r_k + 8'd1;
        default: ;
      endcase
    end
  end

  // Datapath captures: key on accepted start, swap operands after each read wait
  always_ff @(posedge clk) begin
    if (w_accept) r_key <= secret_key;
    if (w_last_wait && (r_state == S_K_WTI || r_state == S_P_WTI)) r_si <= q;
    if (w_last_wait && (r_state == S_K_WTJ || r_state == S_P_WTJ)) r_sj <= q;
  end

endmodule

// File: tb/tb_rc4_keystream_engine.sv
// Directed bench for rc4_keystream_engine: four instances cover key length,
// message length and read latency variants, each with its own S-memory model.
module tb_rc4_keystream_engine;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       start    = '0;
  logic [3:0]       ks_ready = '1;
  logic [31:0]      cur_key  = '0;
  logic [3:0]       wren, rden, ks_valid, busy, done;
  logic [3:0][7:0]  address, data, q, ks_byte, ks_index;

  int tests = 0;
  int fails = 0;
  logic [7:0] got_b [16];
  logic [7:0] got_i [16];
  int   got_n, viol, init_wr, first_rd, rd513;
  logic done_after_start;

  logic [7:0] exp_key  [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
  logic [7:0] exp_wiki [5] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int KB = (g == 1) ? 4 : 3;
    localparam int ML = (g == 1) ? 5 : 9;
    localparam int RL = (g == 2) ? 2 : (g == 3) ? 3 : 1;
    logic [7:0] mem  [256];
    logic [7:0] pipe [RL];

    always @(posedge clk) begin
      if (wren[g]) mem[address[g]] <= data[g];
      pipe[0] <= rden[g] ? mem[address[g]] : 8'h00;
      for (int s = 1; s < RL; s++) pipe[s] <= pipe[s-1];
    end
    assign q[g] = pipe[RL-1];

    rc4_keystream_engine #(.KEY_BYTES(KB), .MSG_LEN(ML), .RD_LAT(RL)) u_dut (
      .clk(clk), .reset(reset), .start(start[g]), .secret_key(cur_key[8*KB-1:0]),
      .address(address[g]), .data(data[g]), .wren(wren[g]), .rden(rden[g]), .q(q[g]),
      .ks_byte(ks_byte[g]), .ks_valid(ks_valid[g]), .ks_ready(ks_ready[g]),
      .ks_index(ks_index[g]), .busy(busy[g]), .done(done[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int g, input logic [31:0] k, input bit stall, input int spulse);
    int   c, nrd;
    bit   held;
    logic [7:0] hb, hi;
    got_n = 0; viol = 0; init_wr = 0; first_rd = -1; rd513 = -1; nrd = 0; held = 0;
    hb = 8'd0; hi = 8'd0;
    @(negedge clk);
    cur_key  = k;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    done_after_start = done[g];
    c = 0;
    while (!done[g] && c < 20000) begin
      start[g] = (c == spulse);
      if (wren[g] && rden[g]) viol++;
      if (ks_valid[g] && (wren[g] || rden[g])) viol++;
      if (c < 256 && wren[g]) init_wr++;
      if (rden[g]) begin
        if (nrd == 0) first_rd = c;
        nrd++;
        if (nrd == 513) rd513 = c;
      end
      if (held && (!ks_valid[g] || ks_byte[g] != hb || ks_index[g] != hi)) viol++;
      ks_ready[g] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ks_valid[g] && ks_ready[g]) begin
        if (got_n < 16) begin
          got_b[got_n] = ks_byte[g];
          got_i[got_n] = ks_index[g];
        end
        got_n++;
      end
      held = ks_valid[g] && !ks_ready[g];
      hb   = ks_byte[g];
      hi   = ks_index[g];
      @(negedge clk);
      c++;
    end
    start[g]    = 1'b0;
    ks_ready[g] = 1'b1;
  endtask

  task automatic check_run(input string tag, input int g, input int n, input bit wiki, input int lat);
    chk({tag, "_done"}, 32'(done[g]), 32'd1);
    chk({tag, "_busy"}, 32'(busy[g]), 32'd0);
    chk({tag, "_done_drop"}, 32'(done_after_start), 32'd0);
    chk({tag, "_count"}, got_n, n);
    for (int m = 0; m < n && m < 16; m++) begin
      chk($sformatf("%s_byte%0d", tag, m), 32'(got_b[m]), 32'(wiki ? exp_wiki[m] : exp_key[m]));
      chk($sformatf("%s_idx%0d", tag, m), 32'(got_i[m]), m);
    end
    chk({tag, "_protocol"}, viol, 0);
    chk({tag, "_init_writes"}, init_wr, 256);
    chk({tag, "_init_len"}, first_rd, 256);
    chk({tag, "_ksa_len"}, rd513 - first_rd, 256 * (4 + 2 * lat));
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("rst_address", 32'(address[0]), 0);
    chk("rst_data", 32'(data[0]), 0);
    chk("rst_mem_en", 32'({wren[0], rden[0]}), 0);
    chk("rst_ks_byte", 32'(ks_byte[0]), 0);
    chk("rst_ks_index", 32'(ks_index[0]), 0);
    chk("rst_flags", 32'({ks_valid[0], busy[0], done[0]}), 0);
    reset = 1'b0;

    run(0, 32'h004B6579, 1'b0, -1);
    check_run("key_l1", 0, 9, 1'b0, 1);
    run(1, 32'h57696B69, 1'b0, -1);
    check_run("wiki", 1, 5, 1'b1, 1);
    run(2, 32'h004B6579, 1'b1, -1);
    check_run("key_l2_stall", 2, 9, 1'b0, 2);
    run(3, 32'h004B6579, 1'b1, 1000);
    check_run("key_l3_startksa", 3, 9, 1'b0, 3);
    run(0, 32'h004B6579, 1'b1, -1);
    check_run("back2back", 0, 9, 1'b0, 1);

    @(negedge clk);
    cur_key  = 32'h004B6579;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    c = 0;
    while (!(ks_valid[0] && ks_index[0] == 8'd3) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk("mid_prga_reached", 32'({ks_valid[0], ks_index[0]}), 32'h103);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_address", 32'(address[0]), 0);
    chk("abort_data", 32'(data[0]), 0);
    chk("abort_mem_en", 32'({wren[0], rden[0]}), 0);
    chk("abort_ks", 32'({ks_byte[0], ks_index[0]}), 0);
    chk("abort_flags", 32'({ks_valid[0], busy[0], done[0]}), 0);
    reset = 1'b0;

    run(0, 32'h004B6579, 1'b0, -1);
    check_run("after_abort", 0, 9, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rc4_keystream_engine.md
Name: rc4_keystream_engine

Overview:
- Single-FSM RC4 engine that owns the external 256x8 S-memory port.
- Runs S-box initialization, then key scheduling with a key of parametrised byte length, then PRGA.
- Streams MSG_LEN keystream bytes out through a valid/ready handshake.
- Replaces the separate init/shuffle FSMs and the RAM port mux with one sequencer that has start/done control and a configurable memory read latency.

Parameters:
KEY_BYTES, 3, secret key length in bytes (1..32); key[i mod KEY_BYTES] selects a byte, byte 0 = most significant byte of secret_key.
MSG_LEN, 32, number of keystream bytes produced per run (1..256).
RD_LAT, 1, S-memory read latency in cycles from address to q (1..3).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE or DONE
secret_key  input  8*KEY_BYTES  key; captured into an internal register on accepted start
address  output  8  S-memory address
data  output  8  S-memory write data
wren  output  1  S-memory write enable
rden  output  1  S-memory read enable
q  input  8  S-memory read data, valid RD_LAT cycles after rden
ks_byte  output  8  keystream byte
ks_valid  output  1  ks_byte valid
ks_ready  input  1  downstream accepts ks_byte
ks_index  output  8  index k of the current keystream byte (0..MSG_LEN-1)
busy  output  1  high from accepted start until DONE
done  output  1  level; high in DONE until next accepted start or reset

Behaviour:
- Reset (sync, clk edge with reset=1): state=IDLE.
  - address, data, ks_byte and ks_index = 0.
  - wren, rden, ks_valid, busy and done = 0.
  - Internal i, j and k = 0.
  - Reset mid-run aborts immediately; the next cycle has wren=0. Memory contents are not restored.
- start in IDLE or DONE: key captured, done cleared, busy=1, go to INIT. start while busy is ignored.
- INIT: one write per cycle with address=i, data=i, wren=1, for i=0..255.
  - Exactly 256 cycles; i wraps to 0 and j is cleared on exit.
- KSA, per i=0..255:
  - RD_I: rden=1, addr=i.
  - WAIT: RD_LAT cycles; capture si=q.
  - Compute j=(j+si+key[i mod KEY_BYTES]) mod 256, 8-bit wrap.
  - RD_J: rden, addr=j; WAIT RD_LAT; capture sj.
  - WR_I: s[i]=sj. WR_J: s[j]=si.
  - Per-i cost is 4+2*RD_LAT cycles (6 at default). When i=j, both writes target the same address and the final value is si, which is correct.
  - After i=255: clear i and j, go to PRGA.
- PRGA, per k:
  - i=i+1 (wrap).
  - Read s[i]; j=j+s[i].
  - Read s[j]; write s[i]=s[j] and s[j]=s[i].
  - Read s[(si+sj) mod 256] into ks_byte.
  - Go to OUT.
- OUT: ks_valid=1 and ks_index=k.
  - ks_byte and ks_index hold stable until ks_ready=1 with ks_valid=1; the transfer happens on that edge.
  - ks_valid is never high during a memory access.
  - After transfer: if k=MSG_LEN-1, go to DONE; else k=k+1 and return to PRGA.
- DONE: busy=0, done=1, ks_valid=0, no memory access.
- Memory port: wren and rden are mutually exclusive every cycle. Both are 0 in IDLE, DONE and OUT. rden is asserted for exactly 1 cycle per read.
- All arithmetic is 8-bit modulo 256. The key index uses a counter that wraps at KEY_BYTES, not a division.

Test Plan:
- Key "Key" (secret_key=24'h4B6579), KEY_BYTES=3, MSG_LEN=9, ks_ready tied 1 -> ks_byte sequence EB 9F 77 81 B7 34 CA 72 A7, then done=1 and busy=0.
- KEY_BYTES=4, secret_key=32'h57696B69 ("Wiki"), MSG_LEN=5 -> 60 44 DB 6D 41.
- RD_LAT=2 and 3, "Key" vector -> same bytes as the first scenario.
  - INIT takes exactly 256 cycles with wren=1.
  - KSA takes exactly 256*(4+2*RD_LAT) cycles.
- Random ks_ready stalls (50%) -> ks_byte and ks_index stable while ks_valid=1 and ks_ready=0; no lost or duplicated bytes; the first scenario's sequence is unchanged.
- start pulsed during KSA -> ignored, output identical. reset asserted mid-PRGA -> next cycle all outputs 0, state IDLE. A fresh start then reproduces the first scenario's sequence.
- Back-to-back runs: start in DONE -> done drops the next cycle, full re-init occurs, output repeats identically.
